pmem_boot: RTL and testbench

//   Parametrised program memory with a boot sequencer for the cpu core. After reset it

---
 rtl/pmem_boot_pkg.sv | 16 +
 rtl/pmem_ram.sv | 35 +++
 rtl/pmem_boot.sv | 175 +++++++++++++++++
 tb/tb_pmem_boot.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_boot_pkg.sv
// Shared types and default sizing for the program-memory boot sequencer.
package pmem_boot_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_RUN   = 2'd3
    } state_e;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_DEPTH    = 2048;
    localparam int unsigned DEF_ADDR_W   = 11;
    localparam int unsigned DEF_RST_HOLD = 4;

endpackage

// File: rtl/pmem_ram.sv
// Single-port synchronous RAM with a registered read port that only updates on a read.
module pmem_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned AW     = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pmem_boot.sv
// Program memory with boot sequencer: clear, stream-load, hold cpu reset, then serve fetches.
// Optional running load checksum output enabled by defining PMEM_CHECKSUM_EN.
module pmem_boot
    import pmem_boot_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned RST_HOLD = DEF_RST_HOLD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reload,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              cpu_rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    output logic              done,
    output logic [ADDR_W:0]   ld_count,
    output logic              ovf
`ifdef PMEM_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD - 1);

    state_e              state_q;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [ADDR_W:0]     ld_count_q, ld_count_d;
    logic [HOLD_W-1:0]   hold_q;
    logic                cpu_rst_q, ld_ready_q, done_q, fetch_valid_q, zero_q, ovf_q;

    logic                ld_fire, fetch_fire, in_range;
    logic                ram_we, ram_re;
    logic [IDX_W-1:0]    ram_addr;
    logic [DATA_W-1:0]   ram_wdata, ram_rdata;

    // ld_ready_q is high exactly in LOAD, done_q exactly in RUN
    assign ld_fire    = ld_valid && ld_ready_q;
    assign in_range   = 32'(fetch_addr) < DEPTH;
    assign fetch_fire = fetch_en && done_q && !reload;
    assign clr_addr_d = clr_addr_q + 1'b1;
    assign ld_count_d = ld_count_q + 1'b1;

    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = clr_addr_q[IDX_W-1:0];
        ram_wdata = '0;
        if (!rst) begin
            case (state_q)
                ST_CLEAR: ram_we = 1'b1;
                ST_LOAD: begin
                    ram_we    = ld_fire;
                    ram_addr  = ld_count_q[IDX_W-1:0];
                    ram_wdata = ld_data;
                end
                ST_RUN: begin
                    ram_re   = fetch_fire && in_range;
                    ram_addr = fetch_addr[IDX_W-1:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_CLEAR;
            clr_addr_q    <= '0;
            ld_count_q    <= '0;
            hold_q        <= '0;
            cpu_rst_q     <= 1'b1;
            ld_ready_q    <= 1'b0;
            done_q        <= 1'b0;
            fetch_valid_q <= 1'b0;
            zero_q        <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            fetch_valid_q <= 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    clr_addr_q <= clr_addr_d;
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q    <= ST_LOAD;
                        ld_ready_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (ld_fire) begin
                        ld_count_q <= ld_count_d;
                        if (ld_last || ld_count_q == LAST_CNT) begin
                            state_q    <= ST_HOLD;
                            ld_ready_q <= 1'b0;
                            hold_q     <= HOLD_INIT;
                            ovf_q      <= !ld_last;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_q == '0) begin
                        state_q   <= ST_RUN;
                        cpu_rst_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (reload) begin
                        state_q    <= ST_CLEAR;
                        clr_addr_q <= '0;
                        ld_count_q <= '0;
                        ovf_q      <= 1'b0;
                        cpu_rst_q  <= 1'b1;
                        done_q     <= 1'b0;
                    end else if (fetch_en) begin
                        fetch_valid_q <= 1'b1;
                        zero_q        <= !in_range;
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

`ifdef PMEM_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    always_ff @(posedge clk) begin
        if (rst || state_q == ST_CLEAR) begin
            checksum_q <= '0;
        end else if (ld_fire) begin
            checksum_q <= checksum_q + ld_data;
        end
    end

    assign checksum = checksum_q;
`endif

    pmem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (IDX_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Out-of-range fetches skip the RAM and return zero via a registered flag
    assign fetch_data  = zero_q ? '0 : ram_rdata;
    assign fetch_valid = fetch_valid_q;
    assign ld_ready    = ld_ready_q;
    assign cpu_rst     = cpu_rst_q;
    assign done        = done_q;
    assign ld_count    = ld_count_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_pmem_boot.sv
// Directed self-checking bench for pmem_boot with a small memory (DEPTH=8).
module tb_pmem_boot;

    localparam int unsigned DW = 32;
    localparam int unsigned DP = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned RH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          reload = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [DW-1:0] ld_data = '0;
    logic          ld_last = 1'b0;
    logic          cpu_rst;
    logic          fetch_en = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic [DW-1:0] fetch_data;
    logic          fetch_valid;
    logic          done;
    logic [AW:0]   ld_count;
    logic          ovf;
`ifdef PMEM_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    int checks = 0;
    int failures = 0;

    pmem_boot #(
        .DATA_W   (DW),
        .DEPTH    (DP),
        .ADDR_W   (AW),
        .RST_HOLD (RH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .reload      (reload),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .cpu_rst     (cpu_rst),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid),
        .done        (done),
        .ld_count    (ld_count),
        .ovf         (ovf)
`ifdef PMEM_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until ld_ready is seen, returning the number of ticks (bounded)
    task automatic wait_ready(output int n);
        n = 0;
        while (!ld_ready && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last);
        int n;
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        n = 0;
        while (!ld_ready && n < 100) begin
            tick();
            n++;
        end
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic do_fetch(input logic [AW-1:0] a, output logic v, output logic [DW-1:0] d);
        fetch_en   = 1'b1;
        fetch_addr = a;
        tick();
        v = fetch_valid;
        d = fetch_data;
        fetch_en = 1'b0;
    endtask

    task automatic do_reload();
        reload   = 1'b1;
        fetch_en = 1'b1;
        fetch_addr = 4'd0;
        tick();
        reload   = 1'b0;
        fetch_en = 1'b0;
        checks++;
        if (cpu_rst !== 1'b1 || done !== 1'b0 || fetch_valid !== 1'b0 || ld_count !== 5'd0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reload_entry got cpu_rst=%b done=%b fv=%b cnt=%0d ovf=%b exp 1 0 0 0 0",
                     cpu_rst, done, fetch_valid, ld_count, ovf);
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (cpu_rst !== 1'b1 || ld_ready !== 1'b0 || done !== 1'b0 || fetch_valid !== 1'b0 ||
            fetch_data !== 32'h0 || ld_count !== 5'd0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_values got cpu_rst=%b rdy=%b done=%b fv=%b fd=%h cnt=%0d ovf=%b",
                     cpu_rst, ld_ready, done, fetch_valid, fetch_data, ld_count, ovf);
        end
        rst = 1'b0;
        wait_ready(n);
        checks++;
        if (n != DP) begin
            failures++;
            $display("FAIL clear_length got %0d cycles exp %0d", n, DP);
        end
        checks++;
        if (cpu_rst !== 1'b1 || ld_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_entry got cpu_rst=%b rdy=%b exp 1 1", cpu_rst, ld_ready);
        end
    endtask

    task automatic test_load_fetch();
        int n;
        logic v;
        logic [DW-1:0] d;
        send(32'hF0000100, 1'b0);
        send(32'hF0000101, 1'b0);
        send(32'h18992000, 1'b1);
        checks++;
        if (ld_count !== 5'd3 || ld_ready !== 1'b0 || cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL load3 got cnt=%0d rdy=%b cpu_rst=%b exp 3 0 1", ld_count, ld_ready, cpu_rst);
        end
        wait_done(n);
        checks++;
        if (n != RH || cpu_rst !== 1'b0) begin
            failures++;
            $display("FAIL hold_len got %0d cycles cpu_rst=%b exp %0d 0", n, cpu_rst, RH);
        end
`ifdef PMEM_CHECKSUM_EN
        checks++;
        if (checksum !== 32'hF8992201) begin
            failures++;
            $display("FAIL checksum got %h exp F8992201", checksum);
        end
`endif
        do_fetch(4'd2, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'h18992000) begin
            failures++;
            $display("FAIL fetch2 got v=%b d=%h exp 1 18992000", v, d);
        end
        do_fetch(4'd3, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'h0) begin
            failures++;
            $display("FAIL fetch3 got v=%b d=%h exp 1 00000000", v, d);
        end
        do_fetch(4'd0, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'hF0000100) begin
            failures++;
            $display("FAIL fetch0 got v=%b d=%h exp 1 f0000100", v, d);
        end
        tick();
        checks++;
        if (fetch_valid !== 1'b0 || fetch_data !== 32'hF0000100) begin
            failures++;
            $display("FAIL fetch_idle got v=%b d=%h exp 0 f0000100", fetch_valid, fetch_data);
        end
        do_fetch(4'd9, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'h0) begin
            failures++;
            $display("FAIL fetch_oor got v=%b d=%h exp 1 00000000", v, d);
        end
        do_fetch(4'd1, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'hF0000101) begin
            failures++;
            $display("FAIL fetch1 got v=%b d=%h exp 1 f0000101", v, d);
        end
`ifdef PMEM_CHECKSUM_EN
        checks++;
        if (checksum !== 32'hF8992201) begin
            failures++;
            $display("FAIL checksum_run got %h exp F8992201", checksum);
        end
`endif
    endtask

    task automatic test_toggle_load();
        int n;
        logic v;
        logic [DW-1:0] d;
        logic [DW-1:0] words [4];
        words[0] = 32'h000000A1;
        words[1] = 32'h000000B2;
        words[2] = 32'h000000C3;
        words[3] = 32'h000000D4;
        do_reload();
        wait_ready(n);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b0;
            ld_data  = 32'hDEADBEEF;
            tick();
            checks++;
            if (ld_count !== 5'(i)) begin
                failures++;
                $display("FAIL toggle_idle%0d got cnt=%0d exp %0d", i, ld_count, i);
            end
            ld_valid = 1'b1;
            ld_data  = words[i];
            ld_last  = (i == 3);
            tick();
            checks++;
            if (ld_count !== 5'(i + 1)) begin
                failures++;
                $display("FAIL toggle_hs%0d got cnt=%0d exp %0d", i, ld_count, i + 1);
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        wait_done(n);
        for (int i = 0; i < 8; i++) begin
            do_fetch(4'(i), v, d);
            checks++;
            if (v !== 1'b1 || d !== ((i < 4) ? words[i] : 32'h0)) begin
                failures++;
                $display("FAIL toggle_rd%0d got v=%b d=%h exp %h", i, v, d, (i < 4) ? words[i] : 32'h0);
            end
        end
        do_fetch(4'd3, v, d);
    endtask

    task automatic test_overflow();
        int n;
        int acc;
        logic v;
        logic [DW-1:0] d;
        do_reload();
        wait_ready(n);
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'(100 + i);
            ld_last  = 1'b0;
            if (ld_ready) acc++;
            tick();
        end
        ld_valid = 1'b0;
        checks++;
        if (acc != 8 || ld_count !== 5'd8 || ovf !== 1'b1 || ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL overflow got acc=%0d cnt=%0d ovf=%b rdy=%b exp 8 8 1 0", acc, ld_count, ovf, ld_ready);
        end
        fetch_en   = 1'b1;
        fetch_addr = 4'd0;
        tick();
        fetch_en = 1'b0;
        checks++;
        if (fetch_valid !== 1'b0 || fetch_data !== 32'h000000D4 || done !== 1'b0) begin
            failures++;
            $display("FAIL fetch_in_hold got v=%b d=%h done=%b exp 0 000000d4 0", fetch_valid, fetch_data, done);
        end
        wait_done(n);
        checks++;
        if (done !== 1'b1 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_run got done=%b ovf=%b exp 1 1", done, ovf);
        end
        do_fetch(4'd7, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'd107) begin
            failures++;
            $display("FAIL ovf_rd7 got v=%b d=%0d exp 1 107", v, d);
        end
        do_fetch(4'd0, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'd100) begin
            failures++;
            $display("FAIL ovf_rd0 got v=%b d=%0d exp 1 100", v, d);
        end
    endtask

    task automatic test_rst_midload();
        int n;
        logic v;
        logic [DW-1:0] d;
        do_reload();
        wait_ready(n);
        send(32'h55, 1'b0);
        send(32'h66, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ld_count !== 5'd0 || ld_ready !== 1'b0 || cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid got cnt=%0d rdy=%b cpu_rst=%b exp 0 0 1", ld_count, ld_ready, cpu_rst);
        end
        wait_ready(n);
        checks++;
        if (n != DP) begin
            failures++;
            $display("FAIL rst_mid_clear got %0d cycles exp %0d", n, DP);
        end
        send(32'h77, 1'b1);
        checks++;
        if (ld_count !== 5'd1 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reload1 got cnt=%0d ovf=%b exp 1 0", ld_count, ovf);
        end
        wait_done(n);
        do_fetch(4'd0, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'h77) begin
            failures++;
            $display("FAIL rst_rd0 got v=%b d=%h exp 1 00000077", v, d);
        end
        do_fetch(4'd1, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'h0) begin
            failures++;
            $display("FAIL rst_rd1 got v=%b d=%h exp 1 00000000", v, d);
        end
        do_fetch(4'd7, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'h0) begin
            failures++;
            $display("FAIL rst_rd7 got v=%b d=%h exp 1 00000000", v, d);
        end
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_toggle_load();
        test_overflow();
        test_rst_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
